// File: rtl/mips_cpu_hilo_unit.sv
// ---------------------------------------------------------------------------
// mips_cpu_hilo_unit
//
// Purpose:
//   Sequencer and architectural HI/LO register pair for the multiply/divide
//   path. On MULT/MULTU/DIV/DIVU it steps the ALU through its control codes,
//   collects the two result words, and commits HI and LO on the same edge.
//   It also handles MTHI/MTLO writes. MFHI/MFLO read o_hi/o_lo directly.
//   o_busy stalls the pipeline while an operation is in flight.
//
// Ports:
//   i_clk          system clock; all state changes on the rising edge
//   i_reset        synchronous, active-high reset
//   i_start        request strobe; sampled only in IDLE/DONE
//   i_op[2:0]      0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO (6,7 ignored)
//   i_rs_data[31:0] MTHI/MTLO write data (operand a, held upstream)
//   i_rt_data[31:0] operand b; used here only for the divide-by-zero check
//   o_alu_ctrl[3:0] ALU control code, decoded from state
//   o_alu_divrst   divider restart pulse, decoded from state
//   i_alu_out[31:0] ALU result word
//   i_alu_divdone  divider complete
//   o_hi, o_lo     architectural HI/LO
//   o_busy         high while a mul/div is in flight
//   o_done         one-cycle pulse in the cycle after commit
//   o_err          one-cycle pulse after a divider timeout
// ---------------------------------------------------------------------------
module mips_cpu_hilo_unit #(
    parameter int DIV_TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    output logic [3:0]  o_alu_ctrl,
    output logic        o_alu_divrst,
    input  logic [31:0] i_alu_out,
    input  logic        i_alu_divdone,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam int CNT_W = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL_HI   = 3'd1,
        S_MUL_LO   = 3'd2,
        S_DIV_RST  = 3'd3,
        S_DIV_WAIT = 3'd4,
        S_DIV_Q    = 3'd5,
        S_DIV_R    = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t           r_state;
    logic [2:0]       r_op;
    logic [31:0]      r_tmp_hi;
    logic [31:0]      r_tmp_lo;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    // Bit 0 of the latched opcode selects the unsigned variant for both
    // MULT/MULTU and DIV/DIVU; in the ALU code it lands on bit 1.
    logic w_unsigned;
    assign w_unsigned = r_op[0];

    // Sequencer: accepts requests, walks the mul/div states, commits HI/LO.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_op     <= 3'd0;
            r_tmp_hi <= 32'd0;
            r_tmp_lo <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                // DONE behaves like IDLE so a back-to-back request loses no cycle.
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (i_start) begin
                        case (i_op)
                            OP_MULT, OP_MULTU: begin
                                r_op    <= i_op;
                                r_state <= S_MUL_HI;
                                r_busy  <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_op <= i_op;
                                if (i_rt_data != 32'd0) begin
                                    r_state <= S_DIV_RST;
                                    r_busy  <= 1'b1;
                                end else begin
                                    // Divide by zero: complete at once, HI/LO kept.
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                end
                            end
                            OP_MTHI: r_hi <= i_rs_data;
                            OP_MTLO: r_lo <= i_rs_data;
                            default: ;
                        endcase
                    end
                end
                S_MUL_HI: begin
                    r_tmp_hi <= i_alu_out;
                    r_state  <= S_MUL_LO;
                    r_busy   <= 1'b1;
                end
                S_MUL_LO: begin
                    r_hi    <= r_tmp_hi;
                    r_lo    <= i_alu_out;
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                S_DIV_RST: begin
                    // divdone during the restart cycle is stale and ignored.
                    r_cnt   <= '0;
                    r_state <= S_DIV_WAIT;
                    r_busy  <= 1'b1;
                end
                S_DIV_WAIT: begin
                    if (i_alu_divdone) begin
                        r_state <= S_DIV_Q;
                        r_busy  <= 1'b1;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + CNT_W'(1);
                        r_busy <= 1'b1;
                    end
                end
                S_DIV_Q: begin
                    r_tmp_lo <= i_alu_out;
                    r_state  <= S_DIV_R;
                    r_busy   <= 1'b1;
                end
                S_DIV_R: begin
                    r_hi    <= i_alu_out;
                    r_lo    <= r_tmp_lo;
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ALU control decode from the current state and latched opcode.
    always_comb begin
        o_alu_ctrl   = 4'b0000;
        o_alu_divrst = 1'b0;
        case (r_state)
            S_MUL_HI:   o_alu_ctrl = w_unsigned ? 4'b1011 : 4'b1001;
            S_MUL_LO:   o_alu_ctrl = w_unsigned ? 4'b1010 : 4'b1000;
            S_DIV_RST: begin
                o_alu_ctrl   = w_unsigned ? 4'b1110 : 4'b1100;
                o_alu_divrst = 1'b1;
            end
            S_DIV_WAIT: o_alu_ctrl = w_unsigned ? 4'b1110 : 4'b1100;
            S_DIV_Q:    o_alu_ctrl = w_unsigned ? 4'b1110 : 4'b1100;
            S_DIV_R:    o_alu_ctrl = w_unsigned ? 4'b1111 : 4'b1101;
            default: begin
                o_alu_ctrl   = 4'b0000;
                o_alu_divrst = 1'b0;
            end
        endcase
    end

    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_err  = r_err;

endmodule

// File: tb/tb_mips_cpu_hilo_unit.sv
// Directed bench for mips_cpu_hilo_unit with a small behavioural ALU.
module tb_mips_cpu_hilo_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [3:0]  alu_ctrl;
    logic        alu_divrst;
    logic [31:0] alu_out;
    logic        alu_divdone;
    logic [31:0] hi, lo;
    logic        busy, done, err;

    int total = 0;
    int bad = 0;
    int divrst_cnt = 0;
    int done_cnt = 0;
    int dcnt = 2000;
    int div_lat = 3;

    mips_cpu_hilo_unit #(.DIV_TIMEOUT(64)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_op(op),
        .i_rs_data(a), .i_rt_data(b),
        .o_alu_ctrl(alu_ctrl), .o_alu_divrst(alu_divrst),
        .i_alu_out(alu_out), .i_alu_divdone(alu_divdone),
        .o_hi(hi), .o_lo(lo), .o_busy(busy), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: result word selected by the control code.
    logic signed [63:0] sprod;
    logic        [63:0] uprod;
    always_comb begin
        sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        uprod = {32'd0, a} * {32'd0, b};
        case (alu_ctrl)
            4'b1001: alu_out = sprod[63:32];
            4'b1000: alu_out = sprod[31:0];
            4'b1011: alu_out = uprod[63:32];
            4'b1010: alu_out = uprod[31:0];
            4'b1100: alu_out = (b != 32'd0) ? 32'($signed(a) / $signed(b)) : 32'd0;
            4'b1101: alu_out = (b != 32'd0) ? 32'($signed(a) % $signed(b)) : 32'd0;
            4'b1110: alu_out = (b != 32'd0) ? a / b : 32'd0;
            4'b1111: alu_out = (b != 32'd0) ? a % b : 32'd0;
            default: alu_out = 32'd0;
        endcase
    end
    assign alu_divdone = (dcnt == div_lat);

    // Divider latency model and event counters.
    always @(posedge clk) begin
        if (alu_divrst) dcnt <= 0;
        else if (dcnt < 2000) dcnt <= dcnt + 1;
        if (alu_divrst) divrst_cnt <= divrst_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        tick(); tick();
        reset = 1'b0;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ctrl", {28'd0, alu_ctrl}, 32'd0);
        chk("rst_divrst", {31'd0, alu_divrst}, 32'd0);

        // MULT -1 * 2
        a = 32'hFFFFFFFF; b = 32'h00000002; op = 3'd0; start = 1'b1;
        tick(); start = 1'b0;
        chk("mult_busy1", {31'd0, busy}, 32'd1);
        chk("mult_ctrl_hi", {28'd0, alu_ctrl}, 32'h9);
        tick();
        chk("mult_busy2", {31'd0, busy}, 32'd1);
        chk("mult_ctrl_lo", {28'd0, alu_ctrl}, 32'h8);
        tick();
        chk("mult_done", {31'd0, done}, 32'd1);
        chk("mult_busy3", {31'd0, busy}, 32'd0);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFE);
        tick();
        chk("mult_done_pulse", {31'd0, done}, 32'd0);

        // MULTU same operands
        op = 3'd1; start = 1'b1;
        tick(); start = 1'b0;
        chk("multu_ctrl_hi", {28'd0, alu_ctrl}, 32'hB);
        tick(); tick();
        chk("multu_done", {31'd0, done}, 32'd1);
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);

        // DIV -7 / 2
        tick();
        divrst_cnt = 0; div_lat = 3;
        a = 32'hFFFFFFF9; b = 32'h2; op = 3'd2; start = 1'b1;
        tick(); start = 1'b0;
        chk("div_divrst", {31'd0, alu_divrst}, 32'd1);
        chk("div_ctrl_rst", {28'd0, alu_ctrl}, 32'hC);
        n = 1;
        while (n < 100 && !done) begin
            chk("div_busy", {31'd0, busy}, 32'd1);
            tick();
            n++;
        end
        chk("div_done", {31'd0, done}, 32'd1);
        chk("div_latency", n, 32'd8);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        chk("div_divrst_cnt", divrst_cnt, 32'd1);

        // MTHI/MTLO then DIVU by zero
        tick();
        a = 32'h1234; op = 3'd4; start = 1'b1;
        tick();
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_done", {31'd0, done}, 32'd0);
        a = 32'h5678; op = 3'd5;
        tick();
        chk("mtlo_hi", hi, 32'h1234);
        chk("mtlo_lo", lo, 32'h5678);
        a = 32'h99; b = 32'h0; op = 3'd3;
        tick(); start = 1'b0;
        chk("dz_done", {31'd0, done}, 32'd1);
        chk("dz_busy", {31'd0, busy}, 32'd0);
        chk("dz_hi", hi, 32'h1234);
        chk("dz_lo", lo, 32'h5678);
        chk("dz_no_divrst", divrst_cnt, 32'd1);
        tick();

        // MTHI then MULT with start held while busy
        a = 32'hCAFEF00D; op = 3'd4; start = 1'b1;
        tick();
        chk("mthi_cafe", hi, 32'hCAFEF00D);
        done_cnt = 0;
        a = 32'd3; b = 32'd5; op = 3'd0;
        tick();
        tick();
        start = 1'b0;
        tick();
        chk("held_done", {31'd0, done}, 32'd1);
        tick(); tick(); tick();
        chk("held_done_cnt", done_cnt, 32'd1);
        chk("held_hi", hi, 32'h0);
        chk("held_lo", lo, 32'hF);

        // Reset while in DIV_WAIT
        div_lat = -1;
        a = 32'd10; b = 32'd3; op = 3'd2; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        chk("rw_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rw_hi", hi, 32'h0);
        chk("rw_lo", lo, 32'h0);
        chk("rw_busy", {31'd0, busy}, 32'd0);
        chk("rw_ctrl", {28'd0, alu_ctrl}, 32'd0);

        // Divider timeout
        a = 32'hAAAA0000; op = 3'd4; start = 1'b1;
        tick();
        a = 32'h5555; op = 3'd5;
        tick();
        a = 32'd10; b = 32'd3; op = 3'd3;
        tick(); start = 1'b0;
        tick();
        n = 0;
        while (n < 200 && !err) begin
            tick();
            n++;
        end
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_cycles", n, 32'd64);
        chk("to_busy", {31'd0, busy}, 32'd0);
        chk("to_hi", hi, 32'hAAAA0000);
        chk("to_lo", lo, 32'h5555);
        tick();
        chk("to_err_pulse", {31'd0, err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
